// File: rtl/dsc_par_accum.sv
// rtl/dsc_par_accum.sv - multi-lane stochastic bitstream popcount accumulator with start/last/done handshake
// Define DSC_ACC_SAT_EN to saturate the accumulator on carry-out instead of wrapping.
module dsc_par_accum #(
  parameter int LANES = 4,
  parameter int WIDTH = 10
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             bs_valid,
  input  logic [LANES-1:0] bs_in,
  input  logic             bs_last,
  output logic             busy,
  output logic [WIDTH-1:0] count,
  output logic [WIDTH-1:0] result,
  output logic             done,
  output logic             overflow
);

  localparam int PW = $clog2(LANES + 1);
  localparam int SW = WIDTH + 1;

  typedef enum logic [1:0] {IDLE, ACCUM, DRAIN} state_t;

  state_t           state_q, state_d;
  logic [PW-1:0]    pc_q, pc_d;
  logic             pc_v_q, pc_v_d;
  logic [WIDTH-1:0] acc_q, acc_d;
  logic [WIDTH-1:0] result_q, result_d;
  logic             done_q, done_d;
  logic             ovf_q, ovf_d;

  logic             accept;
  logic [PW-1:0]    beat_pc;
  logic [WIDTH:0]   sum;
  logic [WIDTH-1:0] acc_upd;

  always_comb begin
    beat_pc = '0;
    for (int i = 0; i < LANES; i++) begin
      beat_pc = beat_pc + PW'(bs_in[i]);
    end
  end

  // The DRAIN-cycle result load uses this same updated value, so the last beat is always included.
  always_comb begin
    sum = {1'b0, acc_q} + SW'(pc_q);
`ifdef DSC_ACC_SAT_EN
    acc_upd = sum[WIDTH] ? {WIDTH{1'b1}} : sum[WIDTH-1:0];
`else
    acc_upd = sum[WIDTH-1:0];
`endif
  end

  always_comb begin
    state_d  = state_q;
    pc_d     = pc_q;
    pc_v_d   = 1'b0;
    acc_d    = acc_q;
    result_d = result_q;
    done_d   = 1'b0;
    ovf_d    = ovf_q;
    accept   = (state_q == ACCUM) && bs_valid;

    if (accept) begin
      pc_d   = beat_pc;
      pc_v_d = 1'b1;
    end
    if (pc_v_q) begin
      acc_d = acc_upd;
      if (sum[WIDTH]) ovf_d = 1'b1;
    end

    case (state_q)
      IDLE: begin
        if (start) begin
          acc_d   = '0;
          pc_v_d  = 1'b0;
          ovf_d   = 1'b0;
          state_d = ACCUM;
        end
      end
      ACCUM: begin
        if (accept && bs_last) state_d = DRAIN;
      end
      DRAIN: begin
        result_d = acc_upd;
        done_d   = 1'b1;
        state_d  = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q  <= IDLE;
      pc_q     <= '0;
      pc_v_q   <= 1'b0;
      acc_q    <= '0;
      result_q <= '0;
      done_q   <= 1'b0;
      ovf_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      pc_q     <= pc_d;
      pc_v_q   <= pc_v_d;
      acc_q    <= acc_d;
      result_q <= result_d;
      done_q   <= done_d;
      ovf_q    <= ovf_d;
    end
  end

  assign busy     = (state_q != IDLE);
  assign count    = acc_q;
  assign result   = result_q;
  assign done     = done_q;
  assign overflow = ovf_q;

endmodule
